pileup_monitor_mc: RTL and testbench

- Multi-channel, parametrised successor of the single-channel event pile-up monitor.
- Tracks outstanding (triggered but not yet read-out) events per readout channel, with hysteresis-based stop/resume back-pressure.
- Adds sticky overflow and underflow flags and per-channel peak occupancy.
- Sits between trigger acceptance and readout sequencers; the aggregate stop gates further trigger acceptance.

---
 rtl/pileup_pkg.sv | 16 +
 rtl/pileup_channel.sv | 116 +++++++++++
 rtl/pileup_monitor_mc.sv | 51 +++++
 tb/tb_pileup_monitor_mc.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pileup_pkg.sv
// Shared constants for the multi-channel pile-up monitor: default sizing,
// stop-state encoding and the packed-bus slice width.
package pileup_pkg;

    localparam int N_CH_DEF  = 4;
    localparam int CNT_W_DEF = 6;

    // Width of one channel's slice inside the packed n_pileup / peak_pileup buses.
    localparam int SLICE_W = CNT_W_DEF;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_STOP = 1'b1
    } stop_state_e;

endpackage

// File: rtl/pileup_channel.sv
// One readout channel: saturating occupancy counter, sticky flags, peak tracker
// and RUN/STOP hysteresis state machine.
module pileup_channel
    import pileup_pkg::*;
#(
    parameter int CNT_W = SLICE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             live_rising,
    input  logic             inc,
    input  logic             dec,
    input  logic [CNT_W-1:0] max_nevent,
    input  logic [CNT_W-1:0] stop_hi,
    input  logic [CNT_W-1:0] stop_lo,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] peak,
    output logic             overflow,
    output logic             underflow,
    output logic             stop_st
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] peak_r;
    logic             ovf_r;
    logic             unf_r;
    stop_state_e      state_r;

    logic [CNT_W-1:0] nxt_s;
    logic             sat_s;
    logic             unf_hit_s;
    logic             ovf_set_s;
    stop_state_e      state_nxt_s;

    // Next occupancy; simultaneous inc and dec cancel even at the rails.
    always_comb begin
        nxt_s     = cnt_r;
        sat_s     = 1'b0;
        unf_hit_s = 1'b0;
        case ({inc, dec})
            2'b10: begin
                if (cnt_r == CNT_MAX) begin
                    sat_s = 1'b1;
                end else begin
                    nxt_s = cnt_r + CNT_ONE;
                end
            end
            2'b01: begin
                if (cnt_r == CNT_ZERO) begin
                    unf_hit_s = 1'b1;
                end else begin
                    nxt_s = cnt_r - CNT_ONE;
                end
            end
            default: begin
                nxt_s = cnt_r;
            end
        endcase
    end

    assign ovf_set_s = sat_s | (nxt_s > max_nevent);

    // Hysteresis next state; the stop_hi test wins when the thresholds overlap.
    always_comb begin
        state_nxt_s = state_r;
        if (nxt_s >= stop_hi) begin
            state_nxt_s = ST_STOP;
        end else if (nxt_s <= stop_lo) begin
            state_nxt_s = ST_RUN;
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Stop state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else if (live_rising) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, peak and sticky flag registers; run-start clear beats strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= CNT_ZERO;
            peak_r <= CNT_ZERO;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else if (live_rising) begin
            cnt_r  <= CNT_ZERO;
            peak_r <= CNT_ZERO;
            ovf_r  <= 1'b0;
            unf_r  <= 1'b0;
        end else begin
            cnt_r  <= nxt_s;
            peak_r <= (nxt_s > peak_r) ? nxt_s : peak_r;
            ovf_r  <= ovf_r | ovf_set_s;
            unf_r  <= unf_r | unf_hit_s;
        end
    end

    assign count     = cnt_r;
    assign peak      = peak_r;
    assign overflow  = ovf_r;
    assign underflow = unf_r;
    assign stop_st   = (state_r == ST_STOP);

endmodule

// File: rtl/pileup_monitor_mc.sv
// Multi-channel pile-up monitor: N_CH independent channel trackers whose stop
// states are ORed into the aggregate trigger back-pressure.
module pileup_monitor_mc
    import pileup_pkg::*;
#(
    parameter int N_CH  = N_CH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  live_rising,
    input  logic [N_CH-1:0]       trig_accepted,
    input  logic [N_CH-1:0]       read_complete,
    input  logic [CNT_W-1:0]      max_nevent,
    input  logic [CNT_W-1:0]      stop_hi,
    input  logic [CNT_W-1:0]      stop_lo,
    output logic [N_CH*CNT_W-1:0] n_pileup,
    output logic [N_CH*CNT_W-1:0] peak_pileup,
    output logic [N_CH-1:0]       read_overflow,
    output logic [N_CH-1:0]       read_underflow,
    output logic [N_CH-1:0]       stop_ch,
    output logic                  stop
);

    genvar g;
    generate
        for (g = 0; g < N_CH; g++) begin : g_ch
            pileup_channel #(
                .CNT_W (CNT_W)
            ) u_ch (
                .clk         (clk),
                .rst_n       (rst_n),
                .live_rising (live_rising),
                .inc         (trig_accepted[g]),
                .dec         (read_complete[g]),
                .max_nevent  (max_nevent),
                .stop_hi     (stop_hi),
                .stop_lo     (stop_lo),
                .count       (n_pileup[g*CNT_W +: CNT_W]),
                .peak        (peak_pileup[g*CNT_W +: CNT_W]),
                .overflow    (read_overflow[g]),
                .underflow   (read_underflow[g]),
                .stop_st     (stop_ch[g])
            );
        end
    endgenerate

    // Aggregate back-pressure is a plain OR of the registered per-channel states.
    assign stop = |stop_ch;

endmodule

// File: tb/tb_pileup_monitor_mc.sv
// Self-checking bench for pileup_monitor_mc: reference model feeding a scoreboard
// queue, a table of short vectors, directed corner sequences and a random run.
module tb_pileup_monitor_mc;

    localparam int NC  = 4;
    localparam int CW  = 6;
    localparam int MAXV = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              live_rising;
    logic [NC-1:0]     trig_accepted;
    logic [NC-1:0]     read_complete;
    logic [CW-1:0]     max_nevent;
    logic [CW-1:0]     stop_hi;
    logic [CW-1:0]     stop_lo;
    logic [NC*CW-1:0]  n_pileup;
    logic [NC*CW-1:0]  peak_pileup;
    logic [NC-1:0]     read_overflow;
    logic [NC-1:0]     read_underflow;
    logic [NC-1:0]     stop_ch;
    logic              stop;

    pileup_monitor_mc #(.N_CH(NC), .CNT_W(CW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .live_rising    (live_rising),
        .trig_accepted  (trig_accepted),
        .read_complete  (read_complete),
        .max_nevent     (max_nevent),
        .stop_hi        (stop_hi),
        .stop_lo        (stop_lo),
        .n_pileup       (n_pileup),
        .peak_pileup    (peak_pileup),
        .read_overflow  (read_overflow),
        .read_underflow (read_underflow),
        .stop_ch        (stop_ch),
        .stop           (stop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NC*CW-1:0] n;
        logic [NC*CW-1:0] pk;
        logic [NC-1:0]    ovf;
        logic [NC-1:0]    unf;
        logic [NC-1:0]    stc;
        logic             stp;
    } exp_t;

    typedef struct {
        logic             lv;
        logic [NC-1:0]    tr;
        logic [NC-1:0]    rd;
        logic [NC*CW-1:0] n;
        logic [NC*CW-1:0] pk;
        logic [NC-1:0]    unf;
    } row_t;

    exp_t sb_q[$];
    row_t tbl[8];

    int n_cmp = 0;
    int n_bad = 0;

    int m_cnt[NC];
    int m_pk[NC];
    bit m_ovf[NC];
    bit m_unf[NC];
    bit m_st[NC];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle at the falling edge, predict, then compare after the rising edge.
    task automatic cycle(input logic lv, input logic [NC-1:0] tr, input logic [NC-1:0] rd);
        exp_t e;
        int   nx;
        live_rising   = lv;
        trig_accepted = tr;
        read_complete = rd;
        for (int i = 0; i < NC; i++) begin
            if (lv) begin
                m_cnt[i] = 0; m_pk[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_st[i] = 0;
            end else begin
                nx = m_cnt[i];
                if (tr[i] && !rd[i]) begin
                    if (m_cnt[i] == MAXV) m_ovf[i] = 1;
                    else nx = m_cnt[i] + 1;
                end else if (!tr[i] && rd[i]) begin
                    if (m_cnt[i] == 0) m_unf[i] = 1;
                    else nx = m_cnt[i] - 1;
                end
                if (nx > int'(max_nevent)) m_ovf[i] = 1;
                if (nx > m_pk[i]) m_pk[i] = nx;
                if (nx >= int'(stop_hi)) m_st[i] = 1;
                else if (nx <= int'(stop_lo)) m_st[i] = 0;
                m_cnt[i] = nx;
            end
        end
        e.stp = 1'b0;
        for (int i = 0; i < NC; i++) begin
            e.n[i*CW +: CW]  = CW'(m_cnt[i]);
            e.pk[i*CW +: CW] = CW'(m_pk[i]);
            e.ovf[i] = m_ovf[i];
            e.unf[i] = m_unf[i];
            e.stc[i] = m_st[i];
            e.stp    = e.stp | m_st[i];
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sb_q.pop_front();
        check("n_pileup",       64'(n_pileup),       64'(e.n));
        check("peak_pileup",    64'(peak_pileup),    64'(e.pk));
        check("read_overflow",  64'(read_overflow),  64'(e.ovf));
        check("read_underflow", 64'(read_underflow), 64'(e.unf));
        check("stop_ch",        64'(stop_ch),        64'(e.stc));
        check("stop",           64'(stop),           64'(e.stp));
    endtask

    task automatic repeat_cycle(input int k, input logic [NC-1:0] tr, input logic [NC-1:0] rd);
        for (int j = 0; j < k; j++) cycle(1'b0, tr, rd);
    endtask

    initial begin
        for (int i = 0; i < NC; i++) begin
            m_cnt[i] = 0; m_pk[i] = 0; m_ovf[i] = 0; m_unf[i] = 0; m_st[i] = 0;
        end
        rst_n = 1'b0;
        live_rising = 1'b0;
        trig_accepted = '0;
        read_complete = '0;
        max_nevent = 6'd45;
        stop_hi = 6'd43;
        stop_lo = 6'd40;

        #12;
        check("reset_n_pileup", 64'(n_pileup),       64'd0);
        check("reset_peak",     64'(peak_pileup),    64'd0);
        check("reset_ovf",      64'(read_overflow),  64'd0);
        check("reset_unf",      64'(read_underflow), 64'd0);
        check("reset_stop_ch",  64'(stop_ch),        64'd0);
        check("reset_stop",     64'(stop),           64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: packing is {ch3, ch2, ch1, ch0}.
        tbl[0] = '{1'b1, 4'b0001, 4'b0000, {6'd0, 6'd0, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b0000};
        tbl[1] = '{1'b0, 4'b1111, 4'b0000, {6'd1, 6'd1, 6'd1, 6'd1}, {6'd1, 6'd1, 6'd1, 6'd1}, 4'b0000};
        tbl[2] = '{1'b0, 4'b0011, 4'b0001, {6'd1, 6'd1, 6'd2, 6'd1}, {6'd1, 6'd1, 6'd2, 6'd1}, 4'b0000};
        tbl[3] = '{1'b0, 4'b0000, 4'b1000, {6'd0, 6'd1, 6'd2, 6'd1}, {6'd1, 6'd1, 6'd2, 6'd1}, 4'b0000};
        tbl[4] = '{1'b0, 4'b0000, 4'b1000, {6'd0, 6'd1, 6'd2, 6'd1}, {6'd1, 6'd1, 6'd2, 6'd1}, 4'b1000};
        tbl[5] = '{1'b0, 4'b0100, 4'b0100, {6'd0, 6'd1, 6'd2, 6'd1}, {6'd1, 6'd1, 6'd2, 6'd1}, 4'b1000};
        tbl[6] = '{1'b0, 4'b0000, 4'b0010, {6'd0, 6'd1, 6'd1, 6'd1}, {6'd1, 6'd1, 6'd2, 6'd1}, 4'b1000};
        tbl[7] = '{1'b1, 4'b1111, 4'b1111, {6'd0, 6'd0, 6'd0, 6'd0}, {6'd0, 6'd0, 6'd0, 6'd0}, 4'b0000};
        for (int r = 0; r < 8; r++) begin
            cycle(tbl[r].lv, tbl[r].tr, tbl[r].rd);
            check($sformatf("tbl%0d_n", r),   64'(n_pileup),       64'(tbl[r].n));
            check($sformatf("tbl%0d_pk", r),  64'(peak_pileup),    64'(tbl[r].pk));
            check($sformatf("tbl%0d_unf", r), 64'(read_underflow), 64'(tbl[r].unf));
        end

        // Hysteresis on ch1: stop at 43, still stopped at 41, released at 40.
        repeat_cycle(42, 4'b0010, 4'b0000);
        check("hyst_42_stop_ch1", 64'(stop_ch[1]), 64'd0);
        cycle(1'b0, 4'b0010, 4'b0000);
        check("hyst_43_stop_ch1", 64'(stop_ch[1]), 64'd1);
        check("hyst_43_stop",     64'(stop),       64'd1);
        repeat_cycle(2, 4'b0000, 4'b0010);
        check("hyst_41_n",        64'(n_pileup[CW +: CW]), 64'd41);
        check("hyst_41_stop_ch1", 64'(stop_ch[1]), 64'd1);
        cycle(1'b0, 4'b0000, 4'b0010);
        check("hyst_40_stop_ch1", 64'(stop_ch[1]), 64'd0);
        check("hyst_40_stop",     64'(stop),       64'd0);

        // Simultaneous strobes on ch2 at count 5.
        cycle(1'b1, 4'b0000, 4'b0000);
        repeat_cycle(5, 4'b0100, 4'b0000);
        repeat_cycle(10, 4'b0100, 4'b0100);
        check("simul_n_ch2",  64'(n_pileup[2*CW +: CW]),    64'd5);
        check("simul_pk_ch2", 64'(peak_pileup[2*CW +: CW]), 64'd5);
        check("simul_flags",  64'({read_overflow, read_underflow}), 64'd0);

        // Underflow on ch3 alone, held afterwards.
        cycle(1'b0, 4'b0000, 4'b1000);
        cycle(1'b0, 4'b0000, 4'b0000);
        check("unf_ch3", 64'(read_underflow), 64'b1000);
        check("unf_n_ch3", 64'(n_pileup[3*CW +: CW]), 64'd0);

        // Overflow at 46 then saturation at 63 on ch0.
        cycle(1'b1, 4'b0000, 4'b0000);
        repeat_cycle(45, 4'b0001, 4'b0000);
        check("ovf_45", 64'(read_overflow[0]), 64'd0);
        cycle(1'b0, 4'b0001, 4'b0000);
        check("ovf_46",   64'(read_overflow[0]), 64'd1);
        check("ovf_46_n", 64'(n_pileup[0 +: CW]), 64'd46);
        repeat_cycle(24, 4'b0001, 4'b0000);
        check("sat_n",  64'(n_pileup[0 +: CW]),    64'd63);
        check("sat_pk", 64'(peak_pileup[0 +: CW]), 64'd63);

        // stop_hi = 0 forces STOP one clock after clear.
        stop_hi = 6'd0;
        cycle(1'b1, 4'b0000, 4'b0000);
        check("hi0_clear", 64'(stop_ch), 64'd0);
        cycle(1'b0, 4'b0000, 4'b0000);
        check("hi0_stop", 64'(stop_ch), 64'hF);
        stop_hi = 6'd43;
        cycle(1'b0, 4'b0000, 4'b0000);
        check("hi43_release", 64'(stop_ch), 64'd0);

        // Random interleaved traffic against the model.
        max_nevent = 6'd30;
        stop_hi = 6'd20;
        stop_lo = 6'd10;
        cycle(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 1000; c++) begin
            logic [NC-1:0] tr;
            logic [NC-1:0] rd;
            for (int i = 0; i < NC; i++) begin
                tr[i] = ($urandom_range(0, 9) < 6);
                rd[i] = ($urandom_range(0, 9) < 5);
            end
            cycle(($urandom_range(0, 199) == 0), tr, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
